// File: rtl/wb_spi_tgt.sv
`timescale 1ns/1ps
// SPI target, CPHA=0, 8-bit MSB-first frames, oversampled in clk_i, with a Wishbone register slave.
//   state   | meaning
//   S_IDLE  | no frame active, MISO released, waiting for CS to fall while enabled
//   S_SHIFT | frame active, MISO driven, bits exchanged on synchronized SCK edges
module wb_spi_tgt #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o,
    input  logic        spi_cs_i,
    input  logic        spi_sck_i,
    input  logic        spi_sdi_i,
    output logic        spi_sdo_o,
    output logic        spi_sdo_oe_o
);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    state_t      r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_tx_sr;
    logic [7:0]  r_rx_sr;
    logic [7:0]  r_tx_buf;
    logic [7:0]  r_rxdata;
    logic [2:0]  r_ctrl;
    logic        r_tx_full;
    logic        r_rx_valid;
    logic        r_rx_ovr;
    logic        r_tx_udr;
    logic        r_irq;
    logic        r_sdo_oe;

    logic        w_sck_s;
    logic        w_cs_s;
    logic        w_sdi_s;
    logic        w_en;
    logic        w_cpol;
    logic        w_rxie;
    logic        w_lead;
    logic        w_trail;
    logic        w_cs_fall;
    logic [7:0]  w_rx_byte;
    logic        w_wb_acc;
    logic        w_tx_wr;
    logic        w_rx_rd;
    logic        w_st_wr;
    logic        w_ctrl_wr;
    logic        w_unused;

    assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s   = r_sdi_sync[SYNC_STAGES-1];
    assign w_en      = r_ctrl[0];
    assign w_cpol    = r_ctrl[1];
    assign w_rxie    = r_ctrl[2];

    // Edge polarity is relative to CPOL: the leading edge always leaves the idle level.
    assign w_lead    = (w_sck_s != r_sck_d) && (w_sck_s != w_cpol);
    assign w_trail   = (w_sck_s != r_sck_d) && (w_sck_s == w_cpol);
    assign w_cs_fall = ~w_cs_s & r_cs_d;
    assign w_rx_byte = {r_rx_sr[6:0], w_sdi_s};

    assign w_wb_acc  = wb_cyc_i & wb_stb_i;
    assign w_tx_wr   = w_wb_acc &  wb_we_i & (wb_adr_i == 2'd0);
    assign w_rx_rd   = w_wb_acc & ~wb_we_i & (wb_adr_i == 2'd1);
    assign w_st_wr   = w_wb_acc &  wb_we_i & (wb_adr_i == 2'd2);
    assign w_ctrl_wr = w_wb_acc &  wb_we_i & (wb_adr_i == 2'd3);
    assign w_unused  = &{1'b0, wb_dat_i[31:8], r_rx_sr[7]};

    assign wb_ack_o     = w_wb_acc;
    assign irq_o        = r_irq;
    assign spi_sdo_oe_o = r_sdo_oe;
    assign spi_sdo_o    = r_sdo_oe & r_tx_sr[7];

    always_comb begin
        wb_dat_o = 32'h0;
        case (wb_adr_i)
            2'd1:    wb_dat_o = {24'h0, r_rxdata};
            2'd2:    wb_dat_o = {27'h0, ~w_cs_s, r_tx_udr, r_rx_ovr, r_rx_valid, r_tx_full};
            2'd3:    wb_dat_o = {29'h0, r_ctrl};
            default: wb_dat_o = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
            r_sdi_sync <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_i};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi_i};
            r_sck_d    <= w_sck_s;
            r_cs_d     <= w_cs_s;
        end
    end

    // Assignment order matters below: later non-blocking writes win, which gives
    // set-over-clear for status flags and buffer-write-over-load for tx_full.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_tx_sr    <= 8'h00;
            r_rx_sr    <= 8'h00;
            r_tx_buf   <= 8'h00;
            r_rxdata   <= 8'h00;
            r_ctrl     <= 3'd0;
            r_tx_full  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ovr   <= 1'b0;
            r_tx_udr   <= 1'b0;
            r_irq      <= 1'b0;
            r_sdo_oe   <= 1'b0;
        end else begin
            r_irq <= w_rxie & r_rx_valid;

            if (w_ctrl_wr)
                r_ctrl <= wb_dat_i[2:0];
            if (w_rx_rd)
                r_rx_valid <= 1'b0;
            if (w_st_wr) begin
                if (wb_dat_i[2])
                    r_rx_ovr <= 1'b0;
                if (wb_dat_i[3])
                    r_tx_udr <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_sdo_oe <= 1'b0;
                    if (w_en && w_cs_fall) begin
                        r_state   <= S_SHIFT;
                        r_sdo_oe  <= 1'b1;
                        r_bit_cnt <= 3'd0;
                        if (r_tx_full) begin
                            r_tx_sr   <= r_tx_buf;
                            r_tx_full <= 1'b0;
                        end else begin
                            r_tx_sr  <= 8'h00;
                            r_tx_udr <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_cs_s || !w_en) begin
                        r_state   <= S_IDLE;
                        r_sdo_oe  <= 1'b0;
                        r_bit_cnt <= 3'd0;
                    end else if (w_lead) begin
                        r_rx_sr   <= w_rx_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            // A read in this very cycle frees the slot, so no overrun.
                            if (!r_rx_valid || w_rx_rd) begin
                                r_rxdata   <= w_rx_byte;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_rx_ovr <= 1'b1;
                            end
                        end
                    end else if (w_trail) begin
                        if (r_bit_cnt != 3'd0) begin
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end else if (r_tx_full) begin
                            r_tx_sr   <= r_tx_buf;
                            r_tx_full <= 1'b0;
                        end else begin
                            r_tx_sr  <= 8'h00;
                            r_tx_udr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sdo_oe <= 1'b0;
                end
            endcase

            if (w_tx_wr) begin
                r_tx_buf  <= wb_dat_i[7:0];
                r_tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_spi_tgt.sv
`timescale 1ns/1ps
// Directed bench for wb_spi_tgt: a bit-banged SPI master plus Wishbone register accesses.
module tb_wb_spi_tgt;

    localparam int HP = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [1:0]  wb_adr_i = 2'd0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;
    logic        spi_cs_i = 1'b1;
    logic        spi_sck_i = 1'b0;
    logic        spi_sdi_i = 1'b0;
    logic        spi_sdo_o;
    logic        spi_sdo_oe_o;

    int n_checks = 0;
    int n_fail = 0;

    wb_spi_tgt #(.SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .irq_o(irq_o),
        .spi_cs_i(spi_cs_i), .spi_sck_i(spi_sck_i), .spi_sdi_i(spi_sdi_i),
        .spi_sdo_o(spi_sdo_o), .spi_sdo_oe_o(spi_sdo_oe_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = adr; wb_dat_i = dat;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 32'h0;
        wb_adr_i = 2'd0;
    endtask

    task automatic wb_read(input logic [1:0] adr, output logic [31:0] dat);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        #1 dat = wb_dat_o;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_adr_i = 2'd0;
    endtask

    // Master side, CPHA=0: MISO is sampled when the leading edge is driven.
    // With rd_last set, RXDATA is read in the cycle the last leading edge takes effect.
    task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input logic cpol,
                            input bit rd_last, output logic [7:0] miso,
                            output logic [31:0] rd_val);
        miso = 8'h00;
        rd_val = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi_i = mosi[7-i];
            cyc(HP);
            spi_sck_i = ~cpol;
            miso[7-i] = spi_sdo_o;
            if (rd_last && i == 7) begin
                cyc(2);
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd1;
                #1 rd_val = wb_dat_o;
                @(posedge clk_i); #1;
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_adr_i = 2'd0;
                cyc(HP - 3);
            end else begin
                cyc(HP);
            end
            spi_sck_i = cpol;
        end
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        n_checks++; if (wb_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", wb_ack_o); end
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq_o); end
        n_checks++; if (spi_sdo_o !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b want 0", spi_sdo_o); end
        n_checks++; if (spi_sdo_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_sdo_oe: got %b want 0", spi_sdo_oe_o); end
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", wb_dat_o); end
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", rd); end
        wb_read(2'd3, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 2'd1;
        #1;
        n_checks++; if (wb_ack_o !== 1'b1) begin n_fail++; $display("FAIL ack_comb: got %b want 1", wb_ack_o); end
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h want 0", wb_dat_o); end
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_adr_i = 2'd0;
    endtask

    task automatic test_mode0;
        logic [31:0] rd;
        logic [7:0]  miso;
        wb_write(2'd3, 32'h1);
        wb_write(2'd0, 32'hA5);
        wb_read(2'd0, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", rd); end
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL m0_status_pre: got %h want 01", rd); end
        spi_cs_i = 1'b0;
        cyc(HP);
        n_checks++; if (spi_sdo_oe_o !== 1'b1) begin n_fail++; $display("FAIL m0_oe: got %b want 1", spi_sdo_oe_o); end
        spi_xfer(8'h3C, 8, 1'b0, 1'b0, miso, rd);
        n_checks++; if (miso !== 8'hA5) begin n_fail++; $display("FAIL m0_miso: got %h want a5", miso); end
        cyc(4);
        spi_cs_i = 1'b1;
        cyc(HP);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0A) begin n_fail++; $display("FAIL m0_status_post: got %h want 0a", rd); end
        wb_read(2'd1, rd);
        n_checks++; if (rd !== 32'h3C) begin n_fail++; $display("FAIL m0_rxdata: got %h want 3c", rd); end
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h08) begin n_fail++; $display("FAIL m0_status_read_clr: got %h want 08", rd); end
        wb_write(2'd2, 32'h0C);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL m0_status_w1c: got %h want 00", rd); end
    endtask

    task automatic test_cpol1;
        logic [31:0] rd;
        logic [7:0]  miso;
        wb_write(2'd3, 32'h3);
        spi_sck_i = 1'b1;
        cyc(HP);
        wb_write(2'd0, 32'h81);
        spi_cs_i = 1'b0;
        cyc(HP);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h10) begin n_fail++; $display("FAIL m2_status_busy: got %h want 10", rd); end
        spi_xfer(8'h7E, 8, 1'b1, 1'b0, miso, rd);
        n_checks++; if (miso !== 8'h81) begin n_fail++; $display("FAIL m2_miso: got %h want 81", miso); end
        cyc(4);
        spi_cs_i = 1'b1;
        cyc(HP);
        wb_read(2'd1, rd);
        n_checks++; if (rd !== 32'h7E) begin n_fail++; $display("FAIL m2_rxdata: got %h want 7e", rd); end
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h08) begin n_fail++; $display("FAIL m2_status: got %h want 08", rd); end
        wb_write(2'd2, 32'h0C);
        wb_write(2'd3, 32'h1);
        spi_sck_i = 1'b0;
        cyc(HP);
    endtask

    task automatic test_udr_ovr;
        logic [31:0] rd;
        logic [7:0]  miso0;
        logic [7:0]  miso1;
        spi_cs_i = 1'b0;
        cyc(HP);
        spi_xfer(8'h11, 8, 1'b0, 1'b0, miso0, rd);
        spi_xfer(8'h22, 8, 1'b0, 1'b0, miso1, rd);
        n_checks++; if (miso0 !== 8'h00) begin n_fail++; $display("FAIL udr_miso0: got %h want 00", miso0); end
        n_checks++; if (miso1 !== 8'h00) begin n_fail++; $display("FAIL udr_miso1: got %h want 00", miso1); end
        cyc(4);
        spi_cs_i = 1'b1;
        cyc(HP);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0E) begin n_fail++; $display("FAIL ovr_status: got %h want 0e", rd); end
        wb_read(2'd1, rd);
        n_checks++; if (rd !== 32'h11) begin n_fail++; $display("FAIL ovr_rxdata: got %h want 11", rd); end
        wb_write(2'd2, 32'h0C);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h00) begin n_fail++; $display("FAIL ovr_status_clr: got %h want 00", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd;
        logic [7:0]  miso;
        spi_cs_i = 1'b0;
        cyc(HP);
        spi_xfer(8'hB0, 5, 1'b0, 1'b0, miso, rd);
        cyc(4);
        spi_cs_i = 1'b1;
        cyc(2);
        n_checks++; if (spi_sdo_oe_o !== 1'b1) begin n_fail++; $display("FAIL abort_oe_early: got %b want 1", spi_sdo_oe_o); end
        cyc(1);
        n_checks++; if (spi_sdo_oe_o !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b want 0", spi_sdo_oe_o); end
        n_checks++; if (spi_sdo_o !== 1'b0) begin n_fail++; $display("FAIL abort_sdo: got %b want 0", spi_sdo_o); end
        cyc(HP);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h08) begin n_fail++; $display("FAIL abort_status: got %h want 08", rd); end
        wb_write(2'd2, 32'h0C);
    endtask

    task automatic test_irq_same_cycle;
        logic [31:0] rd;
        logic [31:0] rd_mid;
        logic [7:0]  miso;
        wb_write(2'd3, 32'h5);
        cyc(2);
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq_o); end
        spi_cs_i = 1'b0;
        cyc(HP);
        spi_xfer(8'h5A, 8, 1'b0, 1'b0, miso, rd);
        n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set: got %b want 1", irq_o); end
        spi_xfer(8'hC3, 8, 1'b0, 1'b1, miso, rd_mid);
        n_checks++; if (rd_mid !== 32'h5A) begin n_fail++; $display("FAIL race_read_old: got %h want 5a", rd_mid); end
        n_checks++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL race_irq: got %b want 1", irq_o); end
        cyc(4);
        spi_cs_i = 1'b1;
        cyc(HP);
        wb_read(2'd2, rd);
        n_checks++; if (rd !== 32'h0A) begin n_fail++; $display("FAIL race_status: got %h want 0a", rd); end
        wb_read(2'd1, rd);
        n_checks++; if (rd !== 32'hC3) begin n_fail++; $display("FAIL race_rxdata: got %h want c3", rd); end
        cyc(2);
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", irq_o); end
        wb_write(2'd2, 32'h0C);
    endtask

    task automatic test_reset_mid_byte;
        logic [31:0] rd;
        logic [7:0]  miso;
        wb_write(2'd3, 32'h1);
        wb_write(2'd0, 32'h99);
        spi_cs_i = 1'b0;
        cyc(HP);
        spi_xfer(8'hF0, 4, 1'b0, 1'b0, miso, rd);
        wb_write(2'd0, 32'h66);
        n_checks++; if (spi_sdo_oe_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_oe: got %b want 1", spi_sdo_oe_o); end
        rst_i = 1'b1;
        cyc(1);
        n_checks++; if (spi_sdo_oe_o !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", spi_sdo_oe_o); end
        n_checks++; if (spi_sdo_o !== 1'b0) begin n_fail++; $display("FAIL rst_sdo: got %b want 0", spi_sdo_o); end
        n_checks++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq_o); end
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 2'd2;
        #1;
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0", wb_dat_o); end
        wb_adr_i = 2'd1;
        #1;
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_rxdata: got %h want 0", wb_dat_o); end
        wb_adr_i = 2'd3;
        #1;
        n_checks++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: got %h want 0", wb_dat_o); end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_adr_i = 2'd0;
        spi_cs_i = 1'b1;
        spi_sck_i = 1'b0;
        cyc(4);
        rst_i = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(3);
        rst_i = 1'b0;
        cyc(2);
        test_reset;
        test_mode0;
        test_cpol1;
        test_udr_ovr;
        test_abort;
        test_irq_same_cycle;
        test_reset_mid_byte;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
